// File: rtl/clock_disp_pkg.sv
// Shared constants and helpers for the six-digit clock display scanner.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package clock_disp_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned BLANK_W    = 4;
  localparam int unsigned BCD_W      = 4;

  localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'h00;

  typedef enum logic [1:0] {
    GRP_SEC  = 2'd0,
    GRP_MIN  = 2'd1,
    GRP_HOUR = 2'd2
  } disp_group_e;

  // Digits pair up into groups: {0,1} sec/day, {2,3} min/month, {4,5} hour/year.
  function automatic disp_group_e digit_group(input logic [IDX_W-1:0] idx);
    disp_group_e grp;
    case (idx)
      3'd0, 3'd1: grp = GRP_SEC;
      3'd2, 3'd3: grp = GRP_MIN;
      default:    grp = GRP_HOUR;
    endcase
    return grp;
  endfunction

  function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] nxt;
    if (idx >= IDX_W'(NUM_DIGITS - 1)) nxt = '0;
    else                               nxt = idx + IDX_W'(1);
    return nxt;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD nibble to active-high 7-segment pattern; non-decimal codes show a dash.
module bcd_to_seg7
  import clock_disp_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed 7-segment scanner with anti-ghost blanking and group blink.
// Optional macro CLOCK_DISPLAY_DP_EN lights decimal-point separators on digits 2 and 4.
module clock_display_scan
  import clock_disp_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES   = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_tick,
  input  logic       blink_tick,
  input  logic       blink_sec_day,
  input  logic       blink_min_month,
  input  logic       blink_hour_year,
  input  logic [7:0] sec_day_bcd,
  input  logic [7:0] min_month_bcd,
  input  logic [7:0] hour_year_bcd,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [BLANK_W-1:0]    BLANK_INIT = BLANK_W'(BLANK_CYCLES);
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = '1;
  localparam logic [SEG_W-1:0]      SEG_IDLE   = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic                  DP_IDLE    = SEG_ACTIVE_LOW;

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BLANK_W-1:0]    blank_q, blank_d;
  logic                  phase_q, phase_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]      seg_q, seg_d;

  logic [BCD_W-1:0]      nibble_c;
  logic [SEG_W-1:0]      dec_c;
  logic [SEG_W-1:0]      pat_c;
  logic                  grp_blink_c;
  logic                  blanking_c;

  assign blanking_c = (blank_q != '0);

  // Scan index, blank window and blink phase; a scan tick always restarts blanking.
  always_comb begin
    idx_d   = idx_q;
    blank_d = blank_q;
    phase_d = phase_q;
    if (blink_tick) phase_d = ~phase_q;
    if (scan_tick) begin
      idx_d   = next_index(idx_q);
      blank_d = BLANK_INIT;
    end else if (blanking_c) begin
      blank_d = blank_q - BLANK_W'(1);
    end
  end

  // Pick the nibble for the current digit, live from the inputs.
  always_comb begin
    nibble_c = sec_day_bcd[3:0];
    case (idx_q)
      3'd0:    nibble_c = sec_day_bcd[3:0];
      3'd1:    nibble_c = sec_day_bcd[7:4];
      3'd2:    nibble_c = min_month_bcd[3:0];
      3'd3:    nibble_c = min_month_bcd[7:4];
      3'd4:    nibble_c = hour_year_bcd[3:0];
      3'd5:    nibble_c = hour_year_bcd[7:4];
      default: nibble_c = sec_day_bcd[3:0];
    endcase
  end

  always_comb begin
    grp_blink_c = 1'b0;
    case (digit_group(idx_q))
      GRP_SEC:  grp_blink_c = blink_sec_day;
      GRP_MIN:  grp_blink_c = blink_min_month;
      GRP_HOUR: grp_blink_c = blink_hour_year;
      default:  grp_blink_c = 1'b0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd_i (nibble_c),
    .seg_c (dec_c)
  );

  // Hidden blink phase blanks segments only; the anode stays enabled.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_IDLE;
    pat_c = (grp_blink_c && !phase_q) ? SEG_OFF : dec_c;
    if (!blanking_c) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = SEG_ACTIVE_LOW ? ~pat_c : pat_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= '0;
      blank_q <= BLANK_INIT;
      phase_q <= 1'b1;
      an_q    <= AN_OFF;
      seg_q   <= SEG_IDLE;
    end else begin
      idx_q   <= idx_d;
      blank_q <= blank_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

`ifdef CLOCK_DISPLAY_DP_EN
  logic dp_q, dp_d;

  // Separators after minutes and hours follow the blink phase.
  always_comb begin
    dp_d = DP_IDLE;
    if (!blanking_c && phase_q && (idx_q == 3'd2 || idx_q == 3'd4)) dp_d = ~DP_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dp_q <= DP_IDLE;
    else      dp_q <= dp_d;
  end

  assign dp = dp_q;
`else
  assign dp = DP_IDLE;
`endif

endmodule
